fft_pair_buffer: RTL and testbench
==================================

# fft_pair_buffer

Radix-2 DIF pairing stage that sits directly upstream of the butterfly. It accepts a serial stream of complex samples, one N-point frame at a time. The first half of each frame is held in an internal delay buffer. When the second half arrives, each sample is paired with its stored partner, so the butterfly receives (A = x[k], B = x[k+N/2]) with twiddle index k and a matching enable/valid.

## Interface
- `N`, 16: points per frame; power of two, ≥ 4.
- `IDX_W`, $clog2(N): width of the in-frame sample counter.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous frame abort; clears frame progress.
- `in_valid`  in  1  `in_data` is accepted this cycle.
- `in_data`  in  complex_product_t  input sample.
- `pair_valid`  out  1  A/B/twiddle valid; drives the butterfly `enable`.
- `A`  out  complex_product_t  buffered first-half sample x[k].
- `B`  out  complex_product_t  current second-half sample x[k+N/2].
- `tw_idx`  out  IDX_W-1  twiddle index k.
- `W_R`, `W_I`  out  16 each, signed  twiddle value for `tw_idx` (see Configuration).
- `pair_last`  out  1  marks the final pair of a frame (k = N/2-1).
- `sample_cnt`  out  IDX_W  index the next accepted sample will take.

## Operation
- `sample_cnt` increments on each accepted sample (`in_valid`=1, `flush`=0) and wraps from N-1 to 0. There is no idle gap between frames.
- First half (`sample_cnt` < N/2):
  - `in_data` is written to buf[`sample_cnt`].
  - No pair is produced; `pair_valid` is 0 on the next cycle.
- Second half (`sample_cnt` ≥ N/2), with k = `sample_cnt` - N/2, the output registers load:
  - A ← buf[k], read in the same cycle as acceptance.
  - B ← `in_data`.
  - `tw_idx` ← k.
  - `pair_last` ← (k == N/2-1).
  - `pair_valid` ← 1.
- No backpressure. The downstream butterfly accepts one pair per cycle unconditionally.
- Next-frame first-half writes may begin the cycle after the last pair is accepted. No read/write hazard exists, because buf[k] is read at acceptance.
- Cycles with `in_valid`=0 change nothing except `pair_valid` ← 0. A, B, `tw_idx` and `pair_last` hold their last values.
- `flush`=1:
  - `sample_cnt` ← 0 and `pair_valid` ← 0.
  - Buffer contents are not cleared; they are stale and never read before being rewritten.
- `flush` and `in_valid` both 1: flush wins and the sample is discarded.
- No arithmetic is performed on sample data. A and B are bit-exact copies of the inputs.

## Timing
- Reset values: `pair_valid`=0, A='0, B='0, `tw_idx`=0, `pair_last`=0, `sample_cnt`=0, `W_R`/`W_I` = twiddle of index 0 (or 0 when the ROM is compiled out). Buffer contents are not reset.
- Latency: second-half sample accepted on edge t → pair visible after edge t+1 (1 cycle). The butterfly adds 1 more, so X/Y appear 2 cycles after B is accepted.
- Throughput: 1 pair/cycle during the second half and 0 during the first half. With continuous input, `pair_valid` runs at a 50% duty in N/2-cycle bursts.
- Reset asserted mid-frame takes effect asynchronously: all outputs go to reset values immediately, and the next accepted sample is index 0.
- `W_R`/`W_I` are registered alongside `tw_idx` and are always aligned with the same pair.

## Configuration
- Macro: `FFT_PAIR_TWIDDLE_ROM_EN`.
- Defined:
  - An internal N/2-entry ROM is built at elaboration.
  - W_R[k] = round(cos(2πk/N)·2^R); W_I[k] = round(-sin(2πk/N)·2^R).
  - Values saturate to the 16-bit signed range.
  - Outputs are registered with the pair.
- Undefined: no ROM is built; `W_R`=`W_I`=0 permanently, and the consumer looks up the twiddle from `tw_idx`.

## Test plan
- N=8, continuous input 1..8 (r=i=value) → four pairs with `pair_valid`=1 on consecutive cycles:
  - (A,B) = (1,5), (2,6), (3,7), (4,8).
  - `tw_idx` = 0,1,2,3.
  - `pair_last` only on (4,8).
  - First pair appears 1 cycle after sample 5 is accepted.
- N=8, two back-to-back frames, 1..8 then 11..18 → second frame yields (11,15) … (14,18), with no corruption from first-frame buffer contents.
- N=8, `in_valid` toggled 1/0 every cycle over 1..8 → same four pairs, each `pair_valid` one cycle wide, with outputs held between pairs.
- N=8, `flush` after sample 6 (simultaneous with sample 7's `in_valid`), then 21..28 → sample 7 is dropped, `sample_cnt`=0, and the next pairs are (21,25) … (24,28).
- N=8, `reset` asserted mid-cycle after sample 3 → all outputs go to zero or reset values asynchronously; restarting with 1..8 gives (1,5) … (4,8).
- `FFT_PAIR_TWIDDLE_ROM_EN` defined, N=8, R=14 → `W_R`/`W_I` = (16384,0), (11585,-11585), (0,-16384), (-11585,-11585) for k=0..3.

Source files
------------

// File: rtl/fft_pair_buffer.sv
// -----------------------------------------------------------------------------
// fft_pair_buffer
//
// Radix-2 DIF pairing stage that sits in front of the butterfly. Samples arrive
// serially, one N-point frame at a time with no gap between frames. The first
// half of each frame is parked in a delay buffer. Each second-half sample
// x[k+N/2] is then paired with its stored partner x[k] and presented, one pair
// per cycle, together with the twiddle index k.
//
// Optional feature (compile-time macro FFT_PAIR_TWIDDLE_ROM_EN):
//   defined   - an N/2-entry twiddle ROM (Q2.14) is built at elaboration, and
//               W_R/W_I are registered alongside tw_idx.
//   undefined - no ROM is built; W_R/W_I are tied to zero and the consumer
//               looks the twiddle up from tw_idx.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   flush       synchronous frame abort; beats in_valid when both are high
//   in_valid    in_data is accepted this cycle
//   in_data     input sample (complex_product_t)
//   pair_valid  A/B/tw_idx/W_R/W_I/pair_last valid; the butterfly enable
//   A           buffered first-half sample x[k]
//   B           second-half sample x[k+N/2]
//   tw_idx      twiddle index k
//   W_R, W_I    twiddle value for tw_idx (zero when the ROM is compiled out)
//   pair_last   final pair of the frame (k == N/2-1)
//   sample_cnt  in-frame index that the next accepted sample will take
// -----------------------------------------------------------------------------
package fft_pair_buffer_pkg;

  typedef struct packed {
    logic signed [15:0] r;
    logic signed [15:0] i;
  } complex_product_t;

endpackage

module fft_pair_buffer
  import fft_pair_buffer_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  input  complex_product_t        in_data,
  output logic                    pair_valid,
  output complex_product_t        A,
  output complex_product_t        B,
  output logic [IDX_W-2:0]        tw_idx,
  output logic signed [15:0]      W_R,
  output logic signed [15:0]      W_I,
  output logic                    pair_last,
  output logic [IDX_W-1:0]        sample_cnt
);

  localparam int               HALF   = N / 2;
  localparam logic [IDX_W-2:0] K_LAST = (IDX_W-1)'(HALF - 1);

  logic             accept;
  logic             second_half;
  logic             load_pair;
  logic [IDX_W-2:0] k;

  // N is a power of two, so the counter MSB marks the second half and the
  // remaining bits are directly the pair index k.
  assign accept      = in_valid & ~flush;
  assign second_half = sample_cnt[IDX_W-1];
  assign k           = sample_cnt[IDX_W-2:0];
  assign load_pair   = accept & second_half;

  // ---------------------------------------------------------------------------
  // Frame position. Wraps N-1 -> 0 naturally because N is a power of two.
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so that all
  // registers sample pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
    end else if (flush) begin
      sample_cnt <= '0;
    end else if (in_valid) begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // First-half delay buffer. buf_mem[k] is read in the same cycle the partner
  // is accepted, so next-frame writes can start immediately without a hazard.
  // ---------------------------------------------------------------------------
  complex_product_t buf_mem [HALF];

  // NOTE: the buffer has no reset on purpose; every entry is rewritten before it
  // is read, and leaving it unreset lets it map onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (accept && !second_half) begin
      buf_mem[k] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pair output registers. Idle and flush cycles only drop pair_valid; the
  // data outputs hold their last pair.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_valid <= 1'b0;
      A          <= '0;
      B          <= '0;
      tw_idx     <= '0;
      pair_last  <= 1'b0;
    end else begin
      pair_valid <= load_pair;
      if (load_pair) begin
        A         <= buf_mem[k];
        B         <= in_data;
        tw_idx    <= k;
        pair_last <= (k == K_LAST);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Twiddle values
  // ---------------------------------------------------------------------------
`ifdef FFT_PAIR_TWIDDLE_ROM_EN
  localparam int  TW_FRAC_W = 14;
  localparam real TWO_PI    = 6.283185307179586;

  // Round half away from zero, then saturate into the 16-bit signed range.
  function automatic logic signed [15:0] to_fixed(input real x);
    real y;
    y = x * real'(1 << TW_FRAC_W);
    if (y >= 0.0) y = y + 0.5;
    else          y = y - 0.5;
    if (y >= 32767.0)  return 16'sh7FFF;
    if (y <= -32768.0) return 16'sh8000;
    return 16'($rtoi(y));
  endfunction

  localparam logic signed [15:0] W0_R = to_fixed(1.0);
  localparam logic signed [15:0] W0_I = 16'sd0;

  logic signed [15:0] rom_r [HALF];
  logic signed [15:0] rom_i [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_rom
    assign rom_r[g] = to_fixed($cos(TWO_PI * real'(g) / real'(N)));
    assign rom_i[g] = to_fixed(-$sin(TWO_PI * real'(g) / real'(N)));
  end

  // Registered with the pair so W_R/W_I always line up with tw_idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      W_R <= W0_R;
      W_I <= W0_I;
    end else if (load_pair) begin
      W_R <= rom_r[k];
      W_I <= rom_i[k];
    end
  end
`else
  assign W_R = '0;
  assign W_I = '0;
`endif

endmodule

// File: tb/tb_fft_pair_buffer.sv
// -----------------------------------------------------------------------------
// tb_fft_pair_buffer
//
// Directed bench for fft_pair_buffer at N=8. Samples carry r=i=value so the
// expected pairs follow directly from the stimulus. Inputs are driven on the
// falling edge, outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_fft_pair_buffer;
  import fft_pair_buffer_pkg::*;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  complex_product_t in_data;
  logic             pair_valid;
  complex_product_t A;
  complex_product_t B;
  logic [IDX_W-2:0] tw_idx;
  logic signed [15:0] W_R;
  logic signed [15:0] W_I;
  logic             pair_last;
  logic [IDX_W-1:0] sample_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FFT_PAIR_TWIDDLE_ROM_EN
  int exp_wr [4] = '{16384, 11585, 0, -11585};
  int exp_wi [4] = '{0, -11585, -16384, -11585};
  int rst_wr     = 16384;
`else
  int exp_wr [4] = '{0, 0, 0, 0};
  int exp_wi [4] = '{0, 0, 0, 0};
  int rst_wr     = 0;
`endif

  fft_pair_buffer #(.N(N), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .pair_valid (pair_valid),
    .A          (A),
    .B          (B),
    .tw_idx     (tw_idx),
    .W_R        (W_R),
    .W_I        (W_I),
    .pair_last  (pair_last),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint cp(input int v);
    logic [31:0] w;
    w = {16'(v), 16'(v)};
    return longint'(w);
  endfunction

  task automatic step(input logic v, input logic f, input int val);
    @(negedge clk);
    in_valid = v;
    flush    = f;
    in_data  = '{r: 16'(val), i: 16'(val)};
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".pair_valid"}, longint'(pair_valid), 0);
    check({tag, ".A"},          longint'(A), 0);
    check({tag, ".B"},          longint'(B), 0);
    check({tag, ".tw_idx"},     longint'(tw_idx), 0);
    check({tag, ".pair_last"},  longint'(pair_last), 0);
    check({tag, ".sample_cnt"}, longint'(sample_cnt), 0);
    check({tag, ".W_R"},        longint'(W_R), rst_wr);
    check({tag, ".W_I"},        longint'(W_I), 0);
  endtask

  // One full frame base..base+7. With gaps=1 an idle cycle follows every
  // sample, and the bench checks that pair_valid drops while data holds.
  task automatic run_frame(input string tag, input int base, input bit gaps);
    int k;
    for (int i = 0; i < N; i++) begin
      step(1'b1, 1'b0, base + i);
      check($sformatf("%s.cnt%0d", tag, i), longint'(sample_cnt), (i + 1) % N);
      if (i < N / 2) begin
        check($sformatf("%s.novalid%0d", tag, i), longint'(pair_valid), 0);
      end else begin
        k = i - N / 2;
        check($sformatf("%s.valid%0d", tag, k), longint'(pair_valid), 1);
        check($sformatf("%s.A%0d", tag, k),     longint'(A), cp(base + k));
        check($sformatf("%s.B%0d", tag, k),     longint'(B), cp(base + i));
        check($sformatf("%s.tw%0d", tag, k),    longint'(tw_idx), k);
        check($sformatf("%s.last%0d", tag, k),  longint'(pair_last), (k == 3) ? 1 : 0);
        check($sformatf("%s.WR%0d", tag, k),    longint'(W_R), exp_wr[k]);
        check($sformatf("%s.WI%0d", tag, k),    longint'(W_I), exp_wi[k]);
      end
      if (gaps) begin
        step(1'b0, 1'b0, 99);
        check($sformatf("%s.gapvalid%0d", tag, i), longint'(pair_valid), 0);
        if (i >= N / 2) begin
          check($sformatf("%s.holdB%0d", tag, i), longint'(B), cp(base + i));
          check($sformatf("%s.holdtw%0d", tag, i), longint'(tw_idx), i - N / 2);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #3;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b0;

    // Continuous frame, then a back-to-back second frame.
    run_frame("f1", 1, 1'b0);
    run_frame("f2", 11, 1'b0);
    step(1'b0, 1'b0, 0);
    check("idle.valid", longint'(pair_valid), 0);
    check("idle.holdA", longint'(A), cp(14));

    // in_valid toggling every cycle.
    run_frame("tog", 1, 1'b1);

    // Flush together with sample 7: sample dropped, frame restarts.
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, i);
    step(1'b1, 1'b1, 7);
    check("flush.cnt",   longint'(sample_cnt), 0);
    check("flush.valid", longint'(pair_valid), 0);
    check("flush.holdB", longint'(B), cp(6));
    run_frame("fl", 21, 1'b0);

    // Asynchronous reset in the middle of a cycle after sample 3.
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, i);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("arst");
    @(negedge clk);
    reset = 1'b0;
    run_frame("rs", 1, 1'b0);

    step(1'b0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
